// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package     : uart_pkg                                             |
// | Description : Shared widths, defaults and the transmit FSM state   |
// |               encoding for the UART transmit engine.               |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package uart_pkg;

   localparam int BITWIDTH          = 8;
   localparam int CLKS_PER_BIT_DFLT = 868;
   localparam int DEPTH_DFLT        = 4;
   // Occupancy is reported as 0..DEPTH, which needs one bit more than a pointer.
   localparam int COUNT_W           = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface   : uart_tx_engine_if                                    |
// | Description : Host-side write and status bundle of the UART        |
// |               transmit engine.                                     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface uart_tx_engine_if;
   import uart_pkg::*;

   logic [BITWIDTH-1:0] dataIn;
   logic                WR;
   logic                FULL;
   logic                EMPTY;
   logic [COUNT_W-1:0]  COUNT;
   logic                OVR;
   logic                BUSY;
   logic                TXDONE;

   // Host side: writes bytes, observes status.
   modport master (
      output dataIn, WR,
      input  FULL, EMPTY, COUNT, OVR, BUSY, TXDONE
   );

   // Engine side.
   modport slave (
      input  dataIn, WR,
      output FULL, EMPTY, COUNT, OVR, BUSY, TXDONE
   );

endinterface : uart_tx_engine_if
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : uart_tx_fifo                                         |
// | Description : Small byte FIFO with registered occupancy flags and  |
// |               a sticky overrun flag for writes while full.         |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = DEPTH_DFLT
)(
   input  logic                Clk,
   input  logic                Rst,
   input  logic                push,
   input  logic                pop,
   input  logic [BITWIDTH-1:0] din,
   output logic [BITWIDTH-1:0] dout,
   output logic                full,
   output logic                empty,
   output logic [COUNT_W-1:0]  count,
   output logic                ovr
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [BITWIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]       r_wptr;
   logic [AW-1:0]       r_rptr;
   logic                w_wr;
   logic                w_rd;
   logic [COUNT_W-1:0]  w_count_nxt;

   // A write is only taken when there is room; a pop only when data exists.
   assign w_wr = push & ~full;
   assign w_rd = pop & ~empty;
   assign dout = r_mem[r_rptr];

   // Next occupancy: a simultaneous write and pop cancel out.
   always_comb begin
      w_count_nxt = count;
      case ({w_wr, w_rd})
         2'b10:   w_count_nxt = count + 1'b1;
         2'b01:   w_count_nxt = count - 1'b1;
         default: w_count_nxt = count;
      endcase
   end

   // Storage array; contents need no reset.
   always_ff @(posedge Clk) begin
      if (w_wr)
         r_mem[r_wptr] <= din;
   end

   // Pointers, occupancy flags and sticky overrun.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         ovr    <= 1'b0;
      end else begin
         if (w_wr)
            r_wptr <= r_wptr + 1'b1;
         if (w_rd)
            r_rptr <= r_rptr + 1'b1;
         count <= w_count_nxt;
         full  <= (w_count_nxt == COUNT_W'(DEPTH));
         empty <= (w_count_nxt == '0);
         // A write against a full FIFO is lost even if a pop frees a slot this cycle.
         if (push && full)
            ovr <= 1'b1;
      end
   end

endmodule : uart_tx_fifo
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : uart_tx_engine                                       |
// | Description : FIFO-buffered UART transmitter, 8N1 framing, LSB     |
// |               first. Define UART_TX_PARITY_EN to insert an even    |
// |               parity bit between data bit 7 and the stop bit.      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
   parameter int DEPTH        = DEPTH_DFLT
)(
   input  logic             Clk,
   input  logic             Rst,
   uart_tx_engine_if.slave  bus,
   output logic             TxD
);

   localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      BIT_LAST  = 3'(BITWIDTH - 1);

   tx_state_t           r_state,  w_state_nxt;
   logic [BAUD_W-1:0]   r_baud,   w_baud_nxt;
   logic [2:0]          r_bitcnt, w_bitcnt_nxt;
   logic [BITWIDTH-1:0] r_shift,  w_shift_nxt;
   logic [BITWIDTH-1:0] w_dout;
   logic                w_pop;
   logic                w_bit_end;
`ifdef UART_TX_PARITY_EN
   logic                r_par,    w_par_nxt;
`endif

   uart_tx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .Clk   (Clk),
      .Rst   (Rst),
      .push  (bus.WR),
      .pop   (w_pop),
      .din   (bus.dataIn),
      .dout  (w_dout),
      .full  (bus.FULL),
      .empty (bus.EMPTY),
      .count (bus.COUNT),
      .ovr   (bus.OVR)
   );

   assign w_bit_end = (r_baud == BAUD_LAST);
   assign bus.BUSY  = (r_state != IDLE);

   // Frame sequencing: pops a byte, then walks start, data, (parity), stop.
   always_comb begin
      w_state_nxt  = r_state;
      w_baud_nxt   = w_bit_end ? '0 : r_baud + 1'b1;
      w_bitcnt_nxt = r_bitcnt;
      w_shift_nxt  = r_shift;
      w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par_nxt    = r_par;
`endif
      case (r_state)
         IDLE: begin
            w_baud_nxt = '0;
            if (!bus.EMPTY) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_dout;
`ifdef UART_TX_PARITY_EN
               w_par_nxt   = ^w_dout;
`endif
               w_state_nxt = START;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_bitcnt_nxt = '0;
               w_state_nxt  = DATA;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_shift_nxt = {1'b0, r_shift[BITWIDTH-1:1]};
               if (r_bitcnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = PARITY;
`else
                  w_state_nxt = STOP;
`endif
               end else begin
                  w_bitcnt_nxt = r_bitcnt + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_bit_end)
               w_state_nxt = STOP;
         end
`endif
         STOP: begin
            if (w_bit_end) begin
               // Chain straight into the next start bit when more data waits.
               if (!bus.EMPTY) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_dout;
`ifdef UART_TX_PARITY_EN
                  w_par_nxt   = ^w_dout;
`endif
                  w_state_nxt = START;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_baud_nxt  = '0;
         end
      endcase
   end

   // State, baud, bit counter and shift register; reset aborts any frame.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_state  <= IDLE;
         r_baud   <= '0;
         r_bitcnt <= '0;
         r_shift  <= '0;
`ifdef UART_TX_PARITY_EN
         r_par    <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_baud   <= w_baud_nxt;
         r_bitcnt <= w_bitcnt_nxt;
         r_shift  <= w_shift_nxt;
`ifdef UART_TX_PARITY_EN
         r_par    <= w_par_nxt;
`endif
      end
   end

   // Line level and end-of-frame pulse decoded from the current state.
   always_comb begin
      TxD        = 1'b1;
      bus.TXDONE = 1'b0;
      case (r_state)
         START:  TxD = 1'b0;
         DATA:   TxD = r_shift[0];
`ifdef UART_TX_PARITY_EN
         PARITY: TxD = r_par;
`endif
         STOP:   bus.TXDONE = w_bit_end;
         default: TxD = 1'b1;
      endcase
   end

endmodule : uart_tx_engine
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_uart_tx_engine                                    |
// | Description : Directed self-checking bench for uart_tx_engine with |
// |               CLKS_PER_BIT=4; honours UART_TX_PARITY_EN.           |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_uart_tx_engine;
   import uart_pkg::*;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   logic TxD;
   int   n_checks = 0;
   int   n_errors = 0;

   // Wrap-around bytes and their hand-computed even-parity bits.
   logic [7:0] c_wb [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h81};
   logic       c_wp [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   always #5 Clk = ~Clk;

   uart_tx_engine_if bus ();

   uart_tx_engine #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (4)
   ) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus),
      .TxD (TxD)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Checks one frame cycle by cycle. skip = frame cycles already elapsed.
   task automatic expect_frame(input logic [7:0] b, input logic p, input int wait_limit, input int skip);
      logic [10:0] seq;
      int          w;
      seq    = '1;
      seq[0] = 1'b0;
      for (int i = 0; i < 8; i++) seq[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
      seq[9] = p;
`else
      seq[9] = 1'b1;
      if (p) seq[10] = 1'b1;
`endif
      if (skip == 0) begin
         w = 0;
         while (TxD !== 1'b0 && w < wait_limit) begin
            tick();
            w++;
         end
         check($sformatf("start_%02h", b), {31'b0, TxD}, 32'd0);
      end
      for (int c = skip; c < FRAME; c++) begin
         check($sformatf("txd_%02h_c%0d", b, c), {31'b0, TxD}, {31'b0, seq[c/CPB]});
         check($sformatf("txdone_%02h_c%0d", b, c), {31'b0, bus.TXDONE}, {31'b0, (c == FRAME-1)});
         check($sformatf("busy_%02h_c%0d", b, c), {31'b0, bus.BUSY}, 32'd1);
         tick();
      end
   endtask

   task automatic send_one(input logic [7:0] b, input logic p);
      bus.dataIn = b;
      bus.WR     = 1'b1;
      tick();
      bus.WR     = 1'b0;
      tick();
      expect_frame(b, p, 0, 0);
   endtask

   // Watches that the line stays idle for n cycles.
   task automatic expect_idle(input string tag, input int n);
      logic saw_low;
      saw_low = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (TxD !== 1'b1 || bus.BUSY !== 1'b0) saw_low = 1'b1;
         tick();
      end
      check(tag, {31'b0, saw_low}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      bus.WR     = 1'b0;
      bus.dataIn = 8'h00;
      Rst        = 1'b0;
      tick();
      tick();
      check("rst_txd",    {31'b0, TxD},        32'd1);
      check("rst_busy",   {31'b0, bus.BUSY},   32'd0);
      check("rst_empty",  {31'b0, bus.EMPTY},  32'd1);
      check("rst_full",   {31'b0, bus.FULL},   32'd0);
      check("rst_count",  {29'b0, bus.COUNT},  32'd0);
      check("rst_ovr",    {31'b0, bus.OVR},    32'd0);
      check("rst_txdone", {31'b0, bus.TXDONE}, 32'd0);
      Rst = 1'b1;
      tick();

      // Single byte
      bus.dataIn = 8'hA5;
      bus.WR     = 1'b1;
      tick();
      bus.WR     = 1'b0;
      check("single_empty_after_wr", {31'b0, bus.EMPTY}, 32'd0);
      check("single_count_after_wr", {29'b0, bus.COUNT}, 32'd1);
      check("single_txd_before_pop", {31'b0, TxD},       32'd1);
      check("single_busy_before_pop", {31'b0, bus.BUSY}, 32'd0);
      tick();
      check("single_count_after_pop", {29'b0, bus.COUNT}, 32'd0);
      expect_frame(8'hA5, 1'b0, 0, 0);
      check("single_busy_end",  {31'b0, bus.BUSY},  32'd0);
      check("single_empty_end", {31'b0, bus.EMPTY}, 32'd1);

      // Back-to-back
      bus.WR     = 1'b1;
      bus.dataIn = 8'h00; tick();
      bus.dataIn = 8'hFF; tick();
      bus.dataIn = 8'h55; tick();
      bus.WR     = 1'b0;
      check("b2b_count2", {29'b0, bus.COUNT}, 32'd2);
      expect_frame(8'h00, 1'b0, 0, 1);
      check("b2b_count1", {29'b0, bus.COUNT}, 32'd1);
      expect_frame(8'hFF, 1'b0, 0, 0);
      check("b2b_count0", {29'b0, bus.COUNT}, 32'd0);
      expect_frame(8'h55, 1'b0, 0, 0);
      check("b2b_busy_end",  {31'b0, bus.BUSY},  32'd0);
      check("b2b_empty_end", {31'b0, bus.EMPTY}, 32'd1);

      // Overrun
      Rst = 1'b0;
      tick();
      Rst = 1'b1;
      bus.WR     = 1'b1;
      bus.dataIn = 8'h11; tick();
      bus.dataIn = 8'h22; tick();
      bus.dataIn = 8'h33; tick();
      bus.dataIn = 8'h44; tick();
      bus.dataIn = 8'h55; tick();
      bus.dataIn = 8'h66; tick();
      bus.WR     = 1'b0;
      check("ovr_full",  {31'b0, bus.FULL},  32'd1);
      check("ovr_flag",  {31'b0, bus.OVR},   32'd1);
      check("ovr_count", {29'b0, bus.COUNT}, 32'd4);
      expect_frame(8'h11, 1'b0, 0, 4);
      expect_frame(8'h22, 1'b0, 0, 0);
      expect_frame(8'h33, 1'b0, 0, 0);
      expect_frame(8'h44, 1'b0, 0, 0);
      expect_frame(8'h55, 1'b0, 0, 0);
      check("ovr_busy_end",  {31'b0, bus.BUSY},  32'd0);
      check("ovr_empty_end", {31'b0, bus.EMPTY}, 32'd1);
      check("ovr_sticky",    {31'b0, bus.OVR},   32'd1);
      expect_idle("ovr_no_sixth_frame", 2 * FRAME);

      // Reset mid-frame, during data bit 3 of 8'h35 (bit 3 = 0)
      bus.WR     = 1'b1;
      bus.dataIn = 8'h35; tick();
      bus.dataIn = 8'h5A; tick();
      bus.dataIn = 8'h96; tick();
      bus.WR     = 1'b0;
      repeat (16) tick();
      check("mid_txd_bit3", {31'b0, TxD},       32'd0);
      check("mid_count",    {29'b0, bus.COUNT}, 32'd2);
      Rst = 1'b0;
      tick();
      check("mid_rst_txd",    {31'b0, TxD},        32'd1);
      check("mid_rst_busy",   {31'b0, bus.BUSY},   32'd0);
      check("mid_rst_count",  {29'b0, bus.COUNT},  32'd0);
      check("mid_rst_ovr",    {31'b0, bus.OVR},    32'd0);
      check("mid_rst_txdone", {31'b0, bus.TXDONE}, 32'd0);
      check("mid_rst_empty",  {31'b0, bus.EMPTY},  32'd1);
      Rst = 1'b1;
      expect_idle("mid_idle_after_rst", 20);
      send_one(8'hC3, 1'b0);

      // Parity-sensitive bytes
      send_one(8'h07, 1'b1);
      send_one(8'h03, 1'b0);
      check("par_busy_end", {31'b0, bus.BUSY}, 32'd0);

      // Wrap-around: writer gated on FULL, reader checks ordering
      fork
         begin
            for (int i = 0; i < 9; i++) begin
               int g;
               g = 0;
               while (bus.FULL && g < 400) begin
                  tick();
                  g++;
               end
               check($sformatf("wrap_gate_%0d", i), {31'b0, bus.FULL}, 32'd0);
               bus.dataIn = c_wb[i];
               bus.WR     = 1'b1;
               tick();
               bus.WR     = 1'b0;
            end
         end
         begin
            for (int k = 0; k < 9; k++)
               expect_frame(c_wb[k], c_wp[k], (k == 0) ? 10 : 0, 0);
         end
      join
      check("wrap_ovr",   {31'b0, bus.OVR},   32'd0);
      check("wrap_empty", {31'b0, bus.EMPTY}, 32'd1);
      check("wrap_busy",  {31'b0, bus.BUSY},  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_uart_tx_engine
`default_nettype wire
